// File: rtl/regfl_pkg.sv
// Constants and FSM encoding shared by the 4x8 register file and its consumers.
package regfl_pkg;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } scan_state_t;

endpackage

// File: rtl/regfl_scan_acc.sv
// Scans a wrap-around window of the register file one entry per cycle and
// returns sum, maximum and first address of the maximum over valid/ready.
module regfl_scan_acc
  import regfl_pkg::*;
#(
  parameter int WIDTH  = regfl_pkg::WIDTH,
  parameter int ADDR_W = regfl_pkg::ADDR_W,
  parameter int SUM_W  = WIDTH + ADDR_W
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len_m1,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SUM_W-1:0]  res_sum,
  output logic [WIDTH-1:0]  res_max,
  output logic [ADDR_W-1:0] res_max_idx
);

  scan_state_t       state_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic [ADDR_W-1:0] len_reg;
  logic [SUM_W-1:0]  sum_reg;
  logic [WIDTH-1:0]  max_reg;
  logic [ADDR_W-1:0] max_idx_reg;
  logic              busy_reg;
  logic              res_valid_reg;
  logic [SUM_W-1:0]  res_sum_reg;
  logic [WIDTH-1:0]  res_max_reg;
  logic [ADDR_W-1:0] res_max_idx_reg;

  logic [SUM_W-1:0]  sum_next;
  logic [WIDTH-1:0]  max_next;
  logic [ADDR_W-1:0] max_idx_next;
  logic              last_beat;

  // Strict compare keeps the earliest address when the maximum repeats.
  always_comb begin
    sum_next     = sum_reg + SUM_W'(rd_data);
    max_next     = max_reg;
    max_idx_next = max_idx_reg;
    if (rd_data > max_reg) begin
      max_next     = rd_data;
      max_idx_next = rd_addr_reg;
    end
    last_beat = (cnt_reg == len_reg);
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_reg       <= IDLE;
      rd_addr_reg     <= '0;
      cnt_reg         <= '0;
      len_reg         <= '0;
      sum_reg         <= '0;
      max_reg         <= '0;
      max_idx_reg     <= '0;
      busy_reg        <= 1'b0;
      res_valid_reg   <= 1'b0;
      res_sum_reg     <= '0;
      res_max_reg     <= '0;
      res_max_idx_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            rd_addr_reg <= base;
            len_reg     <= len_m1;
            cnt_reg     <= '0;
            sum_reg     <= '0;
            max_reg     <= '0;
            max_idx_reg <= base;
            busy_reg    <= 1'b1;
            state_reg   <= SCAN;
          end
        end
        SCAN: begin
          sum_reg     <= sum_next;
          max_reg     <= max_next;
          max_idx_reg <= max_idx_next;
          cnt_reg     <= cnt_reg + ADDR_W'(1);
          // The read address stays on the last scanned entry after the final beat.
          if (last_beat) begin
            res_sum_reg     <= sum_next;
            res_max_reg     <= max_next;
            res_max_idx_reg <= max_idx_next;
            res_valid_reg   <= 1'b1;
            state_reg       <= HOLD;
          end else begin
            rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy        = busy_reg;
  assign rd_addr     = rd_addr_reg;
  assign res_valid   = res_valid_reg;
  assign res_sum     = res_sum_reg;
  assign res_max     = res_max_reg;
  assign res_max_idx = res_max_idx_reg;

endmodule

// File: tb/tb_regfl_scan_acc.sv
// Directed bench for regfl_scan_acc with a behavioural 4x8 register file
// (combinational read, write on the clock edge).
module tb_regfl_scan_acc;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       start;
  logic [1:0] base;
  logic [1:0] len_m1;
  logic       busy;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       res_valid;
  logic       res_ready;
  logic [9:0] res_sum;
  logic [7:0] res_max;
  logic [1:0] res_max_idx;

  logic [7:0] regs [4];
  logic       we;
  logic [1:0] wa;
  logic [7:0] wd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (we) regs[wa] <= wd;
  assign rd_data = regs[rd_addr];

  regfl_scan_acc dut (
    .clk(clk), .rst_b(rst_b), .start(start), .base(base), .len_m1(len_m1),
    .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_max(res_max), .res_max_idx(res_max_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  // Starts a scan and waits for res_valid; optionally writes wr_d to wr_a in
  // the cycle where rd_addr first equals wr_a.
  task automatic scan(input logic [1:0] b, input logic [1:0] l,
                      input logic [9:0] es, input logic [7:0] em, input logic [1:0] ei,
                      input bit do_wr, input logic [1:0] wr_a, input logic [7:0] wr_d);
    int lat;
    logic [1:0] ea;
    bit wrote;
    start = 1'b1; base = b; len_m1 = l;
    tick();
    start = 1'b0; base = ~b; len_m1 = ~l;
    chk("busy_after_start", busy, 1);
    lat = 0; ea = b; wrote = 0;
    while (!res_valid && lat < 8) begin
      chk("rd_addr_seq", rd_addr, ea);
      if (do_wr && !wrote && rd_addr == wr_a) begin
        we = 1'b1; wa = wr_a; wd = wr_d; wrote = 1;
      end
      tick();
      we = 1'b0;
      ea = ea + 2'd1;
      lat++;
    end
    $display("scan base=%0d len_m1=%0d latency=%0d sum=0x%0h max=0x%0h idx=%0d",
             b, l, lat, res_sum, res_max, res_max_idx);
    chk("latency", lat, int'(l) + 1);
    chk("res_valid", res_valid, 1);
    chk("res_sum", res_sum, es);
    chk("res_max", res_max, em);
    chk("res_max_idx", res_max_idx, ei);
  endtask

  task automatic ack();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("valid_after_ack", res_valid, 0);
    chk("busy_after_ack", busy, 0);
  endtask

  initial begin
    rst_b = 1'b1; start = 1'b0; base = '0; len_m1 = '0; res_ready = 1'b0;
    we = 1'b0; wa = '0; wd = '0;
    regs[0] = 8'h00; regs[1] = 8'h00; regs[2] = 8'h00; regs[3] = 8'h00;
    tick(); tick();
    rst_b = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_rd_addr", rd_addr, 0);

    wr(2'd0, 8'h10); wr(2'd1, 8'hF0); wr(2'd2, 8'h05); wr(2'd3, 8'hF0);

    // Full window, repeated maximum: first occurrence wins.
    scan(2'd0, 2'd3, 10'h1F5, 8'hF0, 2'd1, 0, 2'd0, 8'h00);
    ack();
    // Wrap-around window.
    scan(2'd3, 2'd1, 10'h100, 8'hF0, 2'd3, 0, 2'd0, 8'h00);
    ack();
    // Single entry.
    scan(2'd2, 2'd0, 10'h005, 8'h05, 2'd2, 0, 2'd0, 8'h00);

    // Hold with res_ready low while start pulses: result frozen, no new scan.
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; base = 2'd0; len_m1 = 2'd3;
      res_ready = (i == 1) ? 1'b0 : 1'b0;
      tick();
      chk("hold_valid", res_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_sum", res_sum, 10'h005);
      chk("hold_idx", res_max_idx, 2'd2);
    end
    start = 1'b0;
    ack();

    // All-max contents: largest possible sum, index of first entry.
    wr(2'd0, 8'hFF); wr(2'd1, 8'hFF); wr(2'd2, 8'hFF); wr(2'd3, 8'hFF);
    scan(2'd0, 2'd3, 10'h3FC, 8'hFF, 2'd0, 0, 2'd0, 8'h00);
    ack();

    // Reset mid-scan discards everything.
    start = 1'b1; base = 2'd0; len_m1 = 2'd3;
    tick();
    start = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    $display("reset mid-scan busy=%0d valid=%0d sum=0x%0h", busy, res_valid, res_sum);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_sum", res_sum, 0);
    chk("midrst_max", res_max, 0);
    chk("midrst_idx", res_max_idx, 0);
    chk("midrst_rd_addr", rd_addr, 0);

    wr(2'd0, 8'h10); wr(2'd1, 8'hF0); wr(2'd2, 8'h05); wr(2'd3, 8'hF0);
    scan(2'd0, 2'd3, 10'h1F5, 8'hF0, 2'd1, 0, 2'd0, 8'h00);
    ack();

    // Write to the entry in its own read cycle: old value still counted.
    scan(2'd0, 2'd3, 10'h1F5, 8'hF0, 2'd1, 1, 2'd2, 8'h01);
    ack();
    scan(2'd0, 2'd3, 10'h1F1, 8'hF0, 2'd1, 0, 2'd0, 8'h00);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfl_scan_acc.md
Name: regfl_scan_acc

Overview:
- Downstream consumer of the 4x8 register file; owns the file's read port (`rd_addr` out, `rd_data` in).
- On command, reads a contiguous, wrap-around window of entries, one per cycle.
- Produces the window sum, the maximum value and the address of that maximum.
- Returns the result over a valid/ready handshake to the control unit.

Parameters:
- WIDTH, 8: data width of one register-file entry.
- ADDR_W, 2: register-file address width; DEPTH = 2**ADDR_W entries.
- SUM_W, WIDTH+ADDR_W: accumulator width; cannot overflow for any window.

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  reset, synchronous, active-high. Sampled on the clk rising edge; rst_b=1 resets. The name is kept per the codebase.
- start  in  1  scan request; accepted only when busy=0.
- base  in  ADDR_W  first address of the window; sampled with start.
- len_m1  in  ADDR_W  window length minus 1 (1..DEPTH entries); sampled with start.
- busy  out  1  high from the start-accept edge until the result is accepted.
- rd_addr  out  ADDR_W  read address to the register file; driven from a register.
- rd_data  in  WIDTH  combinational read data from the register file for rd_addr.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  SUM_W  unsigned sum of the window.
- res_max  out  WIDTH  unsigned maximum of the window.
- res_max_idx  out  ADDR_W  register-file address of the first occurrence of the max in scan order.

Behaviour:
- FSM states: IDLE, SCAN, HOLD.
- Reset (rst_b=1 at an edge), from any state including mid-SCAN or HOLD:
  - state goes to IDLE.
  - busy, res_valid, res_sum, res_max, res_max_idx and rd_addr all reset to 0.
  - Counters reset to 0.
  - A pending result is discarded.
- IDLE:
  - busy=0, res_valid=0.
  - If start=1 at an edge: ptr<=base, cnt<=0, sum<=0, max<=0, max_idx<=base, then go to SCAN. busy=1 from that edge.
- SCAN:
  - rd_addr=ptr. rd_data is used in the same cycle, since the register file read is combinational.
  - At each edge: sum<=sum+rd_data; max and max_idx are updated only when rd_data>max (strict, so the first occurrence wins).
  - At each edge: ptr<=ptr+1 mod DEPTH (wraps 3->0); cnt<=cnt+1.
  - On the edge where cnt==len_m1: latch the res_* outputs from the updated values, set res_valid=1 and go to HOLD.
- Latency: start accepted at edge k; res_valid rises at edge k+len_m1+1 (1 to DEPTH cycles).
- HOLD:
  - res_* and res_valid stay stable while res_ready=0.
  - On an edge with res_ready=1: res_valid<=0, busy<=0, go to IDLE.
  - A new start is accepted no earlier than the edge after that, with busy=0.
- start while busy=1: ignored, no queueing. base and len_m1 changes while busy are ignored.
- res_ready while res_valid=0: ignored.
- rd_addr outside SCAN holds its last value. The register file tolerates any value there.
- Concurrent writes to the register file during SCAN:
  - Each entry contributes the value present on rd_data in its read cycle.
  - A write to the entry being read takes effect only at that same edge, so the old value is used.
  - No snapshot is taken.
- Arithmetic: all unsigned. Zero-extend rd_data to SUM_W before the add. Maximum possible sum is DEPTH*(2**WIDTH-1) = 0x3FC, which fits.

Decomposition:
- Shared package regfl_pkg holds:
  - WIDTH, ADDR_W, DEPTH constants, shared with the register file.
  - The state encoding for IDLE/SCAN/HOLD as a 2-bit typedef.
- No sub-module is needed. The FSM, wrap pointer and accumulators fit in one module.
- The bench instantiates regfl_scan_acc together with the existing 4x8 register file, driving its write port directly.

Test Plan:
- Preload regs {0x10,0xF0,0x05,0xF0}; start base=0, len_m1=3 -> res_valid after 4 cycles; sum=0x1F5, max=0xF0, max_idx=1; rd_addr sequence 0,1,2,3.
- Same contents; base=3, len_m1=1 (wrap) -> rd_addr 3,0; sum=0x100, max=0xF0, max_idx=3; latency 2 cycles.
- base=2, len_m1=0 -> 1-cycle latency; sum=0x005, max=0x05, max_idx=2. All regs 0xFF, full window -> sum=0x3FC, max_idx=0.
- Hold res_ready=0 for 3 cycles with start pulsed -> res_* stable, busy=1, no new scan. res_ready=1 -> IDLE next edge; a following start is accepted.
- Assert rst_b=1 mid-SCAN (cnt=1) -> next edge: busy=0, res_valid=0, all outputs 0. A fresh full scan then gives a correct result.
- During a full scan, write 0x01 to reg 2 in the same cycle it is read -> 0x05 contributes; a re-scan afterwards gives sum=0x1F1.
